// File: rtl/powerup_speed_ctrl_if.sv
// Signal bundle for the speed power-up sequencer: frame/pixel/tank inputs
// and the sprite, boost and status outputs.
interface powerup_speed_ctrl_if #(
  parameter int SPRITE_LOG2 = 5
);
  logic                       frame_tick;
  logic [9:0]                 DrawX;
  logic [9:0]                 DrawY;
  logic [9:0]                 tank0_x;
  logic [9:0]                 tank0_y;
  logic [9:0]                 tank1_x;
  logic [9:0]                 tank1_y;
  logic [2*SPRITE_LOG2-1:0]   rom_addr;
  logic                       sprite_on;
  logic [1:0]                 boost;
  logic [9:0]                 spawn_x;
  logic [9:0]                 spawn_y;
  logic [1:0]                 state_o;

  modport master (
    output frame_tick, DrawX, DrawY, tank0_x, tank0_y, tank1_x, tank1_y,
    input  rom_addr, sprite_on, boost, spawn_x, spawn_y, state_o
  );

  modport slave (
    input  frame_tick, DrawX, DrawY, tank0_x, tank0_y, tank1_x, tank1_y,
    output rom_addr, sprite_on, boost, spawn_x, spawn_y, state_o
  );
endinterface

// File: rtl/powerup_speed_ctrl.sv
// Speed power-up sequencer: spawn/lifetime/blink/respawn scheduling,
// once-per-frame tank pickup detection, per-tank boost timers and the
// two-stage sprite pixel path (ROM address, then aligned sprite_on).
module powerup_speed_ctrl #(
  parameter int SPRITE_LOG2    = 5,
  parameter int TANK_SIZE      = 32,
  parameter int RESPAWN_FRAMES = 600,
  parameter int LIFE_FRAMES    = 900,
  parameter int BLINK_FRAMES   = 180,
  parameter int BOOST_FRAMES   = 300
) (
  input  logic                Clk,
  input  logic                Reset,
  powerup_speed_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_WAIT  = 2'd0,
    S_SHOW  = 2'd1,
    S_BLINK = 2'd2
  } state_t;

  localparam logic [11:0] RESP_M1  = 12'(RESPAWN_FRAMES - 1);
  localparam logic [11:0] LIFE_M1  = 12'(LIFE_FRAMES - 1);
  localparam logic [11:0] BLINK_AT = 12'(BLINK_FRAMES);
  localparam logic [11:0] BOOST_LD = 12'(BOOST_FRAMES);
  localparam logic [10:0] SPR_W    = 11'(1 << SPRITE_LOG2);
  localparam logic [10:0] TANK_W   = 11'(TANK_SIZE);

  state_t                   state_q, state_d;
  logic [11:0]              fcnt_q, fcnt_d;
  logic [7:0]               lfsr_q;
  logic [9:0]               sx_q, sy_q, sx_d, sy_d;
  logic [11:0]              bcnt0_q, bcnt1_q;
  logic                     ov0, ov1, grant0, grant1;
  logic                     visible, in_x, in_y;
  logic [9:0]               dx, dy;
  logic                     hit_q, sprite_on_q;
  logic [2*SPRITE_LOG2-1:0] rom_addr_q;

  // Strict AABB intersection using 11-bit sums so edges near 1023 do not wrap.
  function automatic logic overlap(input logic [9:0] tx, input logic [9:0] ty,
                                   input logic [9:0] sx, input logic [9:0] sy);
    return ({1'b0, tx} < ({1'b0, sx} + SPR_W)) && ({1'b0, sx} < ({1'b0, tx} + TANK_W)) &&
           ({1'b0, ty} < ({1'b0, sy} + SPR_W)) && ({1'b0, sy} < ({1'b0, ty} + TANK_W));
  endfunction

  assign ov0 = overlap(bus.tank0_x, bus.tank0_y, sx_q, sy_q);
  assign ov1 = overlap(bus.tank1_x, bus.tank1_y, sx_q, sy_q);

  // Next-state, frame counter, spawn position and pickup grants; a pickup
  // takes priority over both the SHOW->BLINK and BLINK->WAIT transitions.
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    sx_d    = sx_q;
    sy_d    = sy_q;
    grant0  = 1'b0;
    grant1  = 1'b0;
    if (bus.frame_tick) begin
      case (state_q)
        S_WAIT: begin
          if (fcnt_q != '0) begin
            fcnt_d = fcnt_q - 12'd1;
          end else begin
            state_d = S_SHOW;
            fcnt_d  = LIFE_M1;
            sx_d    = 10'd64 + {1'b0, lfsr_q[3:0], 5'b0};
            sy_d    = 10'd64 + {2'b0, lfsr_q[6:4], 5'b0};
          end
        end
        S_SHOW, S_BLINK: begin
          if (ov0 || ov1) begin
            grant0  = ov0;
            grant1  = !ov0;
            state_d = S_WAIT;
            fcnt_d  = RESP_M1;
          end else if (state_q == S_SHOW) begin
            if (fcnt_q == BLINK_AT) state_d = S_BLINK;
            else                    fcnt_d  = fcnt_q - 12'd1;
          end else begin
            if (fcnt_q == '0) begin
              state_d = S_WAIT;
              fcnt_d  = RESP_M1;
            end else begin
              fcnt_d = fcnt_q - 12'd1;
            end
          end
        end
        default: begin
          state_d = S_WAIT;
          fcnt_d  = RESP_M1;
        end
      endcase
    end
  end

  // FSM, frame counter and latched spawn position.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_WAIT;
      fcnt_q  <= RESP_M1;
      sx_q    <= '0;
      sy_q    <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
    end
  end

  // Spawn-position LFSR, advanced once per frame.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)               lfsr_q <= 8'hA5;
    else if (bus.frame_tick) lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  // Per-tank boost timers; a grant reloads even while already boosted.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      bcnt0_q <= '0;
      bcnt1_q <= '0;
    end else if (bus.frame_tick) begin
      if (grant0)             bcnt0_q <= BOOST_LD;
      else if (bcnt0_q != '0) bcnt0_q <= bcnt0_q - 12'd1;
      if (grant1)             bcnt1_q <= BOOST_LD;
      else if (bcnt1_q != '0) bcnt1_q <= bcnt1_q - 12'd1;
    end
  end

  assign visible = (state_q == S_SHOW) || ((state_q == S_BLINK) && fcnt_q[3]);
  assign dx      = bus.DrawX - sx_q;
  assign dy      = bus.DrawY - sy_q;
  assign in_x    = ({1'b0, bus.DrawX} >= {1'b0, sx_q}) && ({1'b0, bus.DrawX} < ({1'b0, sx_q} + SPR_W));
  assign in_y    = ({1'b0, bus.DrawY} >= {1'b0, sy_q}) && ({1'b0, bus.DrawY} < ({1'b0, sy_q} + SPR_W));

  // Pixel pipeline: stage 1 registers ROM address and hit, stage 2 delays hit
  // to line up with the ROM's registered read data.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rom_addr_q  <= '0;
      hit_q       <= 1'b0;
      sprite_on_q <= 1'b0;
    end else begin
      rom_addr_q  <= {dy[SPRITE_LOG2-1:0], dx[SPRITE_LOG2-1:0]};
      hit_q       <= visible && in_x && in_y;
      sprite_on_q <= hit_q;
    end
  end

  assign bus.rom_addr  = rom_addr_q;
  assign bus.sprite_on = sprite_on_q;
  assign bus.boost     = {bcnt1_q != '0, bcnt0_q != '0};
  assign bus.spawn_x   = sx_q;
  assign bus.spawn_y   = sy_q;
  assign bus.state_o   = state_q;

endmodule

// File: tb/tb_powerup_speed_ctrl.sv
// Self-checking bench for powerup_speed_ctrl against an age-based
// behavioural model of the pickup life cycle.
module tb_powerup_speed_ctrl;
  localparam int SL   = 5;
  localparam int TS   = 32;
  localparam int RESP = 4;
  localparam int LIFE = 20;
  localparam int BLNK = 8;
  localparam int BST  = 5;

  logic Clk = 1'b0;
  logic Reset;

  powerup_speed_ctrl_if #(.SPRITE_LOG2(SL)) bus ();

  powerup_speed_ctrl #(
    .SPRITE_LOG2(SL), .TANK_SIZE(TS), .RESPAWN_FRAMES(RESP),
    .LIFE_FRAMES(LIFE), .BLINK_FRAMES(BLNK), .BOOST_FRAMES(BST)
  ) dut (
    .Clk(Clk), .Reset(Reset), .bus(bus)
  );

  always #5 Clk = ~Clk;

  int n_vec, n_err;

  // Reference model: pickup is either hidden (hid = ticks since hiding) or on
  // the field (age = ticks since it appeared).
  bit        on_field;
  int        age, hid;
  logic [7:0] m_l;
  int        m_sx, m_sy;
  int        bst[2];
  bit        prev_hit;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    on_field = 0; age = 0; hid = 0; m_l = 8'hA5;
    m_sx = 0; m_sy = 0; bst[0] = 0; bst[1] = 0; prev_hit = 0;
  endtask

  function automatic int m_state();
    if (!on_field) return 0;
    return (age < LIFE - BLNK) ? 1 : 2;
  endfunction

  function automatic bit m_vis();
    if (!on_field) return 0;
    if (age < LIFE - BLNK) return 1;
    return (((LIFE - age) >> 3) & 1) == 1;
  endfunction

  function automatic bit m_ov(input int tx, input int ty);
    return (tx < m_sx + 32) && (m_sx < tx + TS) && (ty < m_sy + 32) && (m_sy < ty + TS);
  endfunction

  function automatic bit m_hit(input int x, input int y);
    return m_vis() && x >= m_sx && x < m_sx + 32 && y >= m_sy && y < m_sy + 32;
  endfunction

  task automatic model_tick();
    bit g0, g1;
    g0 = 0; g1 = 0;
    if (on_field) begin
      if (m_ov(int'(bus.tank0_x), int'(bus.tank0_y)))      g0 = 1;
      else if (m_ov(int'(bus.tank1_x), int'(bus.tank1_y))) g1 = 1;
    end
    if (g0) bst[0] = BST; else if (bst[0] > 0) bst[0]--;
    if (g1) bst[1] = BST; else if (bst[1] > 0) bst[1]--;
    if (on_field) begin
      if (g0 || g1 || age == LIFE) begin on_field = 0; hid = 0; end
      else age++;
    end else begin
      hid++;
      if (hid == RESP) begin
        on_field = 1; age = 0;
        m_sx = 64 + 32 * int'(m_l[3:0]);
        m_sy = 64 + 32 * int'(m_l[6:4]);
      end
    end
    m_l = {m_l[6:0], m_l[7] ^ m_l[5] ^ m_l[4] ^ m_l[3]};
  endtask

  task automatic set_px(input int x, input int y);
    bus.DrawX = 10'(x);
    bus.DrawY = 10'(y);
  endtask

  task automatic set_tanks(input int x0, input int y0, input int x1, input int y1);
    bus.tank0_x = 10'(x0); bus.tank0_y = 10'(y0);
    bus.tank1_x = 10'(x1); bus.tank1_y = 10'(y1);
  endtask

  // One clock; tk=1 makes it a frame tick. Pixel outputs are checked every
  // cycle against the model as it stood before the edge.
  task automatic cycle(input bit tk);
    bit e_hit;
    int e_rom;
    e_hit = m_hit(int'(bus.DrawX), int'(bus.DrawY));
    e_rom = (((int'(bus.DrawY) - m_sy) & 31) << 5) | ((int'(bus.DrawX) - m_sx) & 31);
    bus.frame_tick = tk;
    @(posedge Clk);
    if (tk) model_tick();
    #1;
    bus.frame_tick = 1'b0;
    chk("rom_addr", int'(bus.rom_addr), e_rom);
    chk("sprite_on", int'(bus.sprite_on), int'(prev_hit));
    prev_hit = e_hit;
    if (tk) begin
      chk("state_o", int'(bus.state_o), m_state());
      chk("boost", int'(bus.boost), (int'(bst[1] != 0) << 1) | int'(bst[0] != 0));
      chk("spawn_x", int'(bus.spawn_x), m_sx);
      chk("spawn_y", int'(bus.spawn_y), m_sy);
    end
  endtask

  task automatic wait_state(input int s, input string tag);
    for (int k = 0; k < 200 && m_state() != s; k++) cycle(1);
    chk(tag, int'(bus.state_o), s);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_state"}, int'(bus.state_o), 0);
    chk({tag, "_boost"}, int'(bus.boost), 0);
    chk({tag, "_sx"}, int'(bus.spawn_x), 0);
    chk({tag, "_sy"}, int'(bus.spawn_y), 0);
    chk({tag, "_rom"}, int'(bus.rom_addr), 0);
    chk({tag, "_son"}, int'(bus.sprite_on), 0);
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    Reset = 1'b1;
    bus.frame_tick = 1'b0;
    set_px(0, 0);
    set_tanks(0, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge Clk);
    #1;
    check_reset("reset");
    @(negedge Clk);
    Reset = 1'b0;

    // First spawn on the RESP-th tick.
    for (int i = 0; i < RESP - 1; i++) cycle(1);
    chk("pre_spawn_wait", int'(bus.state_o), 0);
    cycle(1);
    chk("first_spawn", int'(bus.state_o), 1);
    chk("spawn_x_grid", int'(bus.spawn_x >= 64 && bus.spawn_x <= 544 && bus.spawn_x % 32 == 0), 1);
    chk("spawn_y_grid", int'(bus.spawn_y >= 64 && bus.spawn_y <= 288 && bus.spawn_y % 32 == 0), 1);

    // Pixel sweep with the pipeline latency exposed by changing pixels each cycle.
    set_px(m_sx + 3, m_sy + 2); cycle(0);
    chk("rom_0x043", int'(bus.rom_addr), 'h043);
    set_px(m_sx - 1, m_sy + 2); cycle(0);
    chk("son_inside", int'(bus.sprite_on), 1);
    set_px(m_sx + 32, m_sy + 2); cycle(0);
    set_px(0, 0); cycle(0);
    chk("son_left_edge", int'(bus.sprite_on), 0);
    cycle(0);
    chk("son_right_edge", int'(bus.sprite_on), 0);

    // Untouched life: SHOW -> BLINK (gated) -> WAIT -> respawn.
    for (int f = 0; f < 30; f++) begin
      set_px(m_sx + 16, m_sy + 16);
      cycle(0); cycle(0); cycle(1);
    end

    // Tank1 pickup.
    wait_state(1, "reach_show_t1");
    set_tanks(0, 0, m_sx + 10, m_sy - 20);
    cycle(1);
    chk("pickup_t1_boost", int'(bus.boost), 2);
    chk("pickup_t1_state", int'(bus.state_o), 0);
    set_tanks(0, 0, 0, 0);
    for (int i = 0; i < BST; i++) cycle(1);
    chk("t1_boost_expired", int'(bus.boost), 0);

    // Both overlap: tank0 wins.
    wait_state(1, "reach_show_both");
    set_tanks(m_sx, m_sy, m_sx + 4, m_sy + 4);
    cycle(1);
    chk("both_boost", int'(bus.boost), 1);
    set_tanks(0, 0, 0, 0);

    // Re-pickup while tank0 is still boosted reloads its timer.
    wait_state(1, "reach_show_reload");
    chk("still_boosted", int'(bus.boost), 1);
    set_tanks(m_sx - 31, m_sy + 31, 0, 0);
    cycle(1);
    set_tanks(0, 0, 0, 0);
    for (int i = 0; i < BST - 1; i++) cycle(1);
    chk("reload_held", int'(bus.boost), 1);
    cycle(1);
    chk("reload_expired", int'(bus.boost), 0);

    // Randomized frames: random pixels, tanks occasionally on the pickup.
    for (int f = 0; f < 250; f++) begin
      for (int p = 0; p < 3; p++) begin
        if ($urandom_range(0, 1) == 1)
          set_px(m_sx + int'($urandom_range(0, 40)) - 4, m_sy + int'($urandom_range(0, 40)) - 4);
        else
          set_px(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)));
        cycle(0);
      end
      set_tanks(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
                int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)));
      if ($urandom_range(0, 7) == 0)
        set_tanks(m_sx + int'($urandom_range(0, 62)) - 31, m_sy + int'($urandom_range(0, 62)) - 31,
                  int'(bus.tank1_x), int'(bus.tank1_y));
      if ($urandom_range(0, 7) == 0)
        set_tanks(int'(bus.tank0_x), int'(bus.tank0_y),
                  m_sx + int'($urandom_range(0, 62)) - 31, m_sy + int'($urandom_range(0, 62)) - 31);
      cycle(1);
    end

    // Asynchronous reset in the middle of BLINK.
    set_tanks(0, 0, 0, 0);
    wait_state(2, "reach_blink");
    set_px(m_sx + 7, m_sy + 9);
    cycle(0); cycle(0);
    @(negedge Clk);
    Reset = 1'b1;
    #1;
    check_reset("async_rst");
    @(negedge Clk);
    Reset = 1'b0;
    model_reset();
    for (int i = 0; i < RESP; i++) cycle(1);
    chk("respawn_after_rst", int'(bus.state_o), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
